// File: rtl/board_sweep_ctrl.sv
// board_sweep_ctrl: drives every SW_W-bit switch pattern (binary or Gray order)
// into a combinational board design, waits SETTLE cycles, captures the packed
// response and streams one (index, response) record per pattern over valid/ready.
// Optional response signature: define SWEEP_MISR_EN to add the SIG port and a
// 32-bit MISR over every accepted record.
module board_sweep_ctrl #(
  parameter int unsigned SW_W   = 6,
  parameter int unsigned OUT_W  = 48,
  parameter int unsigned SETTLE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  output logic             BUSY,
  output logic             DONE,
  output logic [SW_W-1:0]  SW,
  input  logic [OUT_W-1:0] RESP,
  output logic             REC_VALID,
  input  logic             REC_READY,
  output logic [SW_W-1:0]  REC_IDX,
  output logic [OUT_W-1:0] REC_DATA
`ifdef SWEEP_MISR_EN
  ,
  output logic [31:0]      SIG
`endif
);

  localparam int unsigned IDX_W = SW_W + 1;
  localparam int unsigned CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = {1'b0, {SW_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_EMIT,
    ST_FINISH
  } state_t;

  // Sweep order: plain index, or reflected Gray code of the index.
  function automatic logic [SW_W-1:0] pat(input logic [SW_W-1:0] i, input logic gray);
    pat = gray ? (i ^ (i >> 1)) : i;
  endfunction

  state_t             state_q,     state_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               mode_q,      mode_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [SW_W-1:0]    sw_q,        sw_d;
  logic               rec_valid_q, rec_valid_d;
  logic [SW_W-1:0]    rec_idx_q,   rec_idx_d;
  logic [OUT_W-1:0]   rec_data_q,  rec_data_d;
  logic [IDX_W-1:0]   idx_inc;

  assign idx_inc = idx_q + IDX_W'(1);

`ifdef SWEEP_MISR_EN
  localparam int unsigned NSLICE = (OUT_W + 31) / 32;
  localparam int unsigned PAD_W  = NSLICE * 32;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  logic [31:0] sig_q, sig_d;

  // XOR of all 32-bit slices of the record, top slice zero-padded.
  function automatic logic [31:0] fold(input logic [OUT_W-1:0] d);
    logic [PAD_W-1:0] p;
    p    = PAD_W'(d);
    fold = '0;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      fold = fold ^ p[k*32 +: 32];
    end
  endfunction
`endif

  // Next-state and next-output decode for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sw_d        = sw_q;
    rec_valid_d = rec_valid_q;
    rec_idx_d   = rec_idx_q;
    rec_data_d  = rec_data_q;
`ifdef SWEEP_MISR_EN
    sig_d       = sig_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          idx_d   = '0;
          sw_d    = pat('0, MODE);
          mode_d  = MODE;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
`ifdef SWEEP_MISR_EN
          sig_d   = MISR_SEED;
`endif
        end
      end
      ST_DRIVE: begin
        // Capture on the edge where the settle count reaches zero.
        if (cnt_q == CNT_ONE) begin
          cnt_d       = '0;
          rec_data_d  = RESP;
          rec_idx_d   = idx_q[SW_W-1:0];
          rec_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_EMIT: begin
        if (REC_READY) begin
          rec_valid_d = 1'b0;
`ifdef SWEEP_MISR_EN
          sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold(rec_data_q);
`endif
          if (idx_q == LAST_IDX) begin
            sw_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_inc;
            sw_d    = pat(idx_inc[SW_W-1:0], mode_q);
            cnt_d   = CNT_LOAD;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sw_q        <= '0;
      rec_valid_q <= 1'b0;
      rec_idx_q   <= '0;
      rec_data_q  <= '0;
`ifdef SWEEP_MISR_EN
      sig_q       <= MISR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sw_q        <= sw_d;
      rec_valid_q <= rec_valid_d;
      rec_idx_q   <= rec_idx_d;
      rec_data_q  <= rec_data_d;
`ifdef SWEEP_MISR_EN
      sig_q       <= sig_d;
`endif
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign SW        = sw_q;
  assign REC_VALID = rec_valid_q;
  assign REC_IDX   = rec_idx_q;
  assign REC_DATA  = rec_data_q;
`ifdef SWEEP_MISR_EN
  assign SIG       = sig_q;
`endif

endmodule

// File: tb/tb_board_sweep_ctrl.sv
// Scoreboard bench for board_sweep_ctrl: stimulus pushes the expected record
// stream, a negedge monitor pops and compares every accepted record, checks
// stall stability and DONE timing. SIG is checked when SWEEP_MISR_EN is defined.
module tb_board_sweep_ctrl;

  localparam int unsigned SW_W   = 6;
  localparam int unsigned OUT_W  = 48;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned NPAT   = 1 << SW_W;

  typedef struct {
    logic [SW_W-1:0]  idx;
    logic [OUT_W-1:0] data;
  } rec_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic             MODE = 1'b0;
  logic             REC_READY = 1'b0;
  logic             BUSY, DONE, REC_VALID;
  logic [SW_W-1:0]  SW, REC_IDX;
  logic [OUT_W-1:0] RESP, REC_DATA;
`ifdef SWEEP_MISR_EN
  logic [31:0]      SIG;
`endif

  board_sweep_ctrl #(.SW_W(SW_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
    .BUSY(BUSY), .DONE(DONE), .SW(SW), .RESP(RESP),
    .REC_VALID(REC_VALID), .REC_READY(REC_READY),
    .REC_IDX(REC_IDX), .REC_DATA(REC_DATA)
`ifdef SWEEP_MISR_EN
    , .SIG(SIG)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0, stalls = 0, rec_cnt = 0, vc = 0, rdy_mode = 0;
  bit sweep_live = 0, done_seen = 0, stall_prev = 0, flip_en = 0;
  logic [SW_W-1:0]  flip_pat = '0, prev_idx = '0;
  logic [OUT_W-1:0] prev_data = '0;
  logic [31:0]      key = 32'h1234_5678, sig_exp = 32'hFFFF_FFFF;
  logic [SW_W-1:0]  sw_d1 = '0, sw_d2 = '0, sw_d3 = '0;
  rec_t             q[$];

  function automatic logic [SW_W-1:0] pat(input int i, input logic m);
    logic [SW_W-1:0] v;
    v = SW_W'(i);
    return m ? (v ^ (v >> 1)) : v;
  endfunction

  // Board model: a pseudo-random response whose low bits echo the switches.
  function automatic logic [OUT_W-1:0] resp_of(input logic [SW_W-1:0] s, input logic [31:0] k,
                                               input bit fl, input logic [SW_W-1:0] fp);
    logic [63:0] h;
    logic [OUT_W-1:0] r;
    h = {32'(s) * 32'h9E37_79B1, k ^ {26'b0, s}};
    r = h[OUT_W-1:0];
    r[SW_W-1:0] = s;
    if (fl && s == fp) r[0] = ~r[0];
    return r;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [OUT_W-1:0] d);
    logic [63:0] p;
    p = 64'(d);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ p[31:0] ^ p[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Board response settles three cycles after SW changes.
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    sw_d1 <= SW;
    sw_d2 <= sw_d1;
    sw_d3 <= sw_d2;
  end
  assign RESP = resp_of(sw_d3, key, flip_en, flip_pat);

  // Monitor: drives READY for the coming edge, then checks what that edge will accept.
  always @(negedge CLK) begin
    if (RST) begin
      stall_prev = 0;
      vc         = 0;
      REC_READY  = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(REC_VALID), 64'd1);
        check("stall_idx", 64'(REC_IDX), 64'(prev_idx));
        check("stall_data", 64'(REC_DATA), 64'(prev_data));
      end
      vc = REC_VALID ? vc + 1 : 0;
      case (rdy_mode)
        0:       REC_READY = 1'b1;
        1:       REC_READY = (vc >= 3);
        default: REC_READY = ($urandom_range(0, 3) != 0);
      endcase
      if (REC_VALID && !REC_READY) begin
        stalls++;
        stall_prev = 1;
        prev_idx   = REC_IDX;
        prev_data  = REC_DATA;
      end else begin
        stall_prev = 0;
      end
      if (REC_VALID && REC_READY) begin
        if (q.size() == 0) flag("unexpected_record");
        else begin
          rec_t e;
          e = q.pop_front();
          check("rec_idx", 64'(REC_IDX), 64'(e.idx));
          check("rec_data", 64'(REC_DATA), 64'(e.data));
          rec_cnt++;
        end
      end
      if (DONE) begin
        if (!sweep_live) flag("unexpected_done");
        else begin
          check("done_time", 64'(cyc - start_cyc), 64'(NPAT * (SETTLE + 1) + stalls));
          check("done_all_records", 64'(q.size()), 64'd0);
          check("done_busy", 64'(BUSY), 64'd0);
          check("done_sw", 64'(SW), 64'd0);
`ifdef SWEEP_MISR_EN
          check("done_sig", 64'(SIG), 64'(sig_exp));
`endif
        end
        sweep_live = 0;
        done_seen  = 1;
      end
    end
  end

  task automatic start_sweep(input logic m, input int rm);
    rec_t r;
    rdy_mode  = rm;
    stalls    = 0;
    rec_cnt   = 0;
    done_seen = 0;
    q.delete();
    sig_exp = 32'hFFFF_FFFF;
    for (int i = 0; i < int'(NPAT); i++) begin
      r.idx  = SW_W'(i);
      r.data = resp_of(pat(i, m), key, flip_en, flip_pat);
      q.push_back(r);
      sig_exp = misr_step(sig_exp, r.data);
    end
    @(negedge CLK);
    #1;
    MODE  = m;
    START = 1'b1;
    @(negedge CLK);
    start_cyc  = cyc;
    sweep_live = 1;
    #1;
    START = 1'b0;
    MODE  = ~m;
    check("busy_after_start", 64'(BUSY), 64'd1);
    check("sw_first", 64'(SW), 64'd0);
    check("valid_after_start", 64'(REC_VALID), 64'd0);
`ifdef SWEEP_MISR_EN
    check("sig_reseed", 64'(SIG), 64'hFFFF_FFFF);
`endif
  endtask

  task automatic wait_done();
    for (int k = 0; k < 4000 && !done_seen; k++) @(negedge CLK);
    if (!done_seen) flag("done_timeout");
    @(negedge CLK);
    check("done_one_cycle", 64'(DONE), 64'd0);
`ifdef SWEEP_MISR_EN
    check("sig_hold", 64'(SIG), 64'(sig_exp));
`endif
  endtask

  task automatic wait_recs(input int n);
    int k;
    for (k = 0; k < 2000 && rec_cnt < n; k++) @(negedge CLK);
    if (rec_cnt < n) flag("rec_count_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(BUSY), 64'd0);
    check({tag, "_done"}, 64'(DONE), 64'd0);
    check({tag, "_sw"}, 64'(SW), 64'd0);
    check({tag, "_valid"}, 64'(REC_VALID), 64'd0);
    check({tag, "_idx"}, 64'(REC_IDX), 64'd0);
    check({tag, "_data"}, 64'(REC_DATA), 64'd0);
`ifdef SWEEP_MISR_EN
    check({tag, "_sig"}, 64'(SIG), 64'hFFFF_FFFF);
`endif
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    #1;
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Binary, Gray, fixed back-pressure and random back-pressure sweeps.
    start_sweep(1'b0, 0); wait_done();
    start_sweep(1'b1, 0); wait_done();
    start_sweep(1'b0, 1); wait_done();
    key = $urandom;
    start_sweep(1'b1, 2); wait_done();

    // START while busy is ignored; reset mid-sweep aborts with no DONE.
    start_sweep(1'b0, 0);
    wait_recs(10);
    #1;
    START = 1'b1;
    @(negedge CLK);
    #1;
    START = 1'b0;
    wait_recs(20);
    #1;
    RST = 1'b1;
    START = 1'b1;
    q.delete();
    sweep_live = 0;
    @(negedge CLK);
    check_reset_outputs("midreset");
    #1;
    RST = 1'b0;
    START = 1'b0;
    repeat (30) @(negedge CLK);
    check("idle_after_reset_busy", 64'(BUSY), 64'd0);
    start_sweep(1'b0, 0); wait_done();

    // Signature sweeps: two identical, then one with a single flipped bit.
    key = 32'hCAFE_F00D;
    start_sweep(1'b1, 0); wait_done();
    start_sweep(1'b1, 0); wait_done();
    flip_en  = 1;
    flip_pat = pat(5, 1'b1);
    start_sweep(1'b1, 2); wait_done();
    flip_en  = 0;

    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
